wb_mem_slave: RTL
=================

# wb_mem_slave

Wishbone B3 slave responder sitting on the shared bus behind the 5-way round-robin grant. Whichever master holds the grant drives `wbs_*` into this block, which terminates single and incrementing-burst cycles against an internal synchronous word RAM. Responses are registered `ack`/`err`, with a programmable first-beat wait count and single-cycle-per-beat burst throughput.

## Interface
- `AW`, default 10: word-address bits; RAM depth is 2^AW words of 32 bits.
- `WAIT`, default 0: extra wait cycles inserted before the first beat of every cycle (0..15).
- Reset is `wb_rst_i`, asynchronous, active-high. Clock is `wb_clk_i`.
- `wb_clk_i`, input, 1: clock.
- `wb_rst_i`, input, 1: asynchronous active-high reset.
- `wbs_cyc_i`, input, 1: bus cycle valid.
- `wbs_stb_i`, input, 1: strobe.
- `wbs_we_i`, input, 1: 1 = write.
- `wbs_sel_i`, input, 4: byte enables; bit n covers byte lane n, data bits [8n+7:8n].
- `wbs_adr_i`, input, 32: byte address; bits [1:0] are ignored.
- `wbs_dat_i`, input, 32: write data.
- `wbs_cti_i`, input, 3: cycle type. 000 = classic, 010 = incrementing burst, 111 = end of burst; all other codes are treated as classic.
- `wbs_bte_i`, input, 2: burst wrap. 00 = linear, 01 = wrap4, 10 = wrap8, 11 = wrap16.
- `wbs_dat_o`, output, 32: read data.
- `wbs_ack_o`, output, 1: registered transfer acknowledge.
- `wbs_err_o`, output, 1: registered error; out-of-range address.
- `wbs_rty_o`, output, 1: retry; constant 0.

## Operation
- **States:** `IDLE`, `WAIT`, `XFER`.
- **Reset values:**
  - `ack_o`, `err_o`, `rty_o` = 0.
  - `dat_o` = 0.
  - State = `IDLE`; internal word address = 0; burst flag = 0.
  - RAM contents are not reset.
- **Accept (IDLE, `cyc&stb` sampled high):**
  - Latch word index `adr[AW+1:2]`.
  - Latch range-error flag `(adr[31:AW+2] != 0)`.
  - Latch burst flag `(cti==010)`.
  - Issue a RAM read at the word index.
  - Go to `WAIT` if `WAIT>0`, otherwise go to `XFER`.
- **WAIT:** counts `WAIT` cycles, then goes to `XFER`. `dat_o` and the RAM read are refreshed on the final wait cycle.
- **XFER, in-range:** `ack_o`=1 and `dat_o`=RAM[index].
  - Write: at the edge ending an ack cycle with `stb_i`=1 and `we_i`=1, write the lanes selected by `sel_i`; unselected lanes are unchanged.
  - Burst continues while `stb_i` and `cti_i==010` on the ack cycle:
    - Advance the index per `bte`. Wrap-N keeps index bits above log2(N) and increments only the low log2(N) bits modulo N.
    - Linear increments modulo 2^AW, with no error at the top of memory.
    - Read the RAM at the new index; `ack_o` stays 1 the next cycle.
  - `cti_i==111`, a non-burst cycle, or the burst flag at 0: this ack is the last beat; go to `IDLE`, and `ack_o`=0 the next cycle.
  - `stb_i`=0 during a burst: `ack_o`=0 and the index holds. When `stb_i` returns, `ack_o`=1 one cycle later with no further wait states.
- **XFER, out-of-range:** `err_o`=1 for exactly one cycle; no RAM write; `dat_o` unchanged; bursts terminate after this beat; return to `IDLE`.
- **Abort:** `cyc_i` sampled 0 in any state forces `IDLE` on the next edge and drops `ack_o`/`err_o`. No write happens unless the edge also qualifies as an ack edge.
- `ack_o` and `err_o` are never high together.

## Timing
- **Classic latency:** `ack_o` rises `1+WAIT` cycles after the edge that first samples `cyc&stb` in `IDLE`.
- **Classic throughput:** one transfer per `2+WAIT` cycles. After a terminating ack there is always one cycle with `ack_o`=0 before `IDLE` can accept again, so there is never a double ack on a held `stb`.
- **Burst:** first beat as classic, then one beat per cycle. The last ack is the cycle in which the master drives `cti=111`.
- **Read data:** valid in the same cycle as `ack_o`. Write data is consumed at the edge ending the ack cycle.
- **Grant change:** the arbiter only moves grant after `cyc` drops, so a new master's request is accepted from `IDLE` with no extra idle cycle beyond the post-ack cycle.
- **Reset mid-cycle:** outputs go to 0 immediately (asynchronously) and the state returns to `IDLE`. A write on the reset edge is not performed.

## Test plan
- **Classic write/read, `WAIT`=0:**
  - Stimulus: write `0xDEADBEEF` to `0x0000_0010` with `sel`=1111, then read the same address.
  - Required: ack 1 cycle after the request; read returns `0xDEADBEEF`; ack is low for 1 cycle between the transfers.
- **Byte lanes:**
  - Stimulus: write `0x11223344` to `0x0000_0020` with `sel`=0101 over a word preloaded with `0xAAAAAAAA`.
  - Required: the read returns `0xAA22AA44`.
- **Wrap4 burst read:**
  - Stimulus: preload words 0..7 with their index, then burst-read from byte address `0x8` (word 2) with `bte`=01 for 4 beats, ending with `cti`=111.
  - Required: data 2, 3, 0, 1 on consecutive acks; ack low on the following cycle.
- **Out-of-range address:**
  - Stimulus: `AW`=10, write to `0x0000_1000`.
  - Required: `err_o` high for 1 cycle, `ack_o` low, and word 0 unchanged.
- **`WAIT`=3 plus burst stall:**
  - Stimulus: linear burst from word 5 with `stb` dropped for 2 cycles after beat 2.
  - Required: first ack 4 cycles after the request; data 5, 6, a 2-cycle gap, then 7, 8.
- **Abort/reset:**
  - Stimulus: deassert `cyc` mid-burst, then assert `wb_rst_i` during a `WAIT` count.
  - Required: `ack_o` low the next cycle, state back in `IDLE`, no stray write, and all outputs 0 immediately on reset.

Source files
------------

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone B3 slave backed by a 2^AW x 32 synchronous RAM.
// Handles classic cycles and incrementing bursts (linear or wrap4/8/16).
// The first beat of every cycle can be delayed by WAIT cycles; after that,
// each burst beat takes one cycle. ack/err are registered, so a master that
// drops stb mid-burst still sees one ack with stb low. The slave holds the
// index across that ack and does not count it as a transfer.
module wb_mem_slave #(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt, w_rd_idx, w_adr_idx, w_burst_idx;
  logic          r_burst, w_burst_nxt;
  logic          r_rng_err, w_rng_err_nxt, w_adr_rng_err;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_ack, w_ack_nxt;
  logic          r_err, w_err_nxt;
  logic [31:0]   r_dat;
  logic          w_rd_en, w_wr_en;
  logic [31:0]   r_mem [0:(1<<AW)-1];

  // Next burst index: wrap modes keep the upper bits and count only the low bits.
  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx,
                                             input logic [1:0]    bte);
    logic [AW-1:0] mask;
    logic [AW-1:0] inc;
    inc = idx + AW'(1'b1);
    case (bte)
      2'b01:   mask = AW'(4'd3);
      2'b10:   mask = AW'(4'd7);
      2'b11:   mask = AW'(4'd15);
      default: mask = '1;
    endcase
    return (idx & ~mask) | (inc & mask);
  endfunction

  assign w_adr_idx     = wbs_adr_i[AW+1:2];
  assign w_adr_rng_err = ((wbs_adr_i >> (AW + 2)) != 32'd0);
  assign w_burst_idx   = next_idx(r_idx, wbs_bte_i);

  assign wbs_dat_o = r_dat;
  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbs_rty_o = 1'b0;

  // Next-state, response and RAM-port decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_burst_nxt   = r_burst;
    w_rng_err_nxt = r_rng_err;
    w_cnt_nxt     = r_cnt;
    w_ack_nxt     = r_ack;
    w_err_nxt     = r_err;
    w_rd_en       = 1'b0;
    w_rd_idx      = r_idx;
    w_wr_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ack_nxt = 1'b0;
        w_err_nxt = 1'b0;
        if (wbs_cyc_i && wbs_stb_i) begin
          w_idx_nxt     = w_adr_idx;
          w_rng_err_nxt = w_adr_rng_err;
          w_burst_nxt   = (wbs_cti_i == 3'b010);
          if (WAIT == 0) begin
            w_state_nxt = S_XFER;
            w_ack_nxt   = !w_adr_rng_err;
            w_err_nxt   = w_adr_rng_err;
            w_rd_en     = !w_adr_rng_err;
            w_rd_idx    = w_adr_idx;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(WAIT - 1);
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_XFER;
          w_ack_nxt   = !r_rng_err;
          w_err_nxt   = r_rng_err;
          w_rd_en     = !r_rng_err;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_XFER: begin
        if (!wbs_cyc_i) begin
          // Abort: no write even if an ack was pending.
          w_state_nxt = S_IDLE;
          w_ack_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
        end else if (r_err) begin
          // Error beat always ends the cycle.
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b0;
        end else if (r_ack) begin
          if (wbs_stb_i) begin
            w_wr_en = wbs_we_i && !wb_rst_i;
            if (r_burst && (wbs_cti_i == 3'b010)) begin
              w_idx_nxt = w_burst_idx;
              w_rd_idx  = w_burst_idx;
              w_rd_en   = 1'b1;
              w_ack_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_ack_nxt   = 1'b0;
            end
          end else begin
            // Master stalled during an ack cycle: hold the index.
            w_ack_nxt = 1'b0;
          end
        end else if (wbs_stb_i) begin
          // Resume after a stall with no wait states.
          w_ack_nxt = 1'b1;
          w_rd_en   = 1'b1;
        end else begin
          w_ack_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
      end
    endcase
  end

  // Control registers and read-data register; cleared asynchronously on reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_burst   <= 1'b0;
      r_rng_err <= 1'b0;
      r_cnt     <= 4'd0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_burst   <= w_burst_nxt;
      r_rng_err <= w_rng_err_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      if (w_rd_en) begin
        r_dat <= r_mem[w_rd_idx];
      end
    end
  end

  // Byte-lane RAM write at the edge that ends an ack cycle; contents are not reset.
  always_ff @(posedge wb_clk_i) begin
    if (w_wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (wbs_sel_i[n]) begin
          r_mem[r_idx][8*n +: 8] <= wbs_dat_i[8*n +: 8];
        end
      end
    end
  end

endmodule
